// File: rtl/demux_pkg.sv
// Shared widths and types for the 1-to-16 demultiplexer datapath.
package demux_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned N_OUT = 16;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_OUT-1:0] onehot_t;

endpackage : demux_pkg

// File: rtl/dec_4to16.sv
// Combinational binary-to-one-hot decoder; all lines low when the enable is low.
module dec_4to16
  import demux_pkg::*;
(
  input  sel_t    i_idx,
  input  logic    i_en,
  output onehot_t o_onehot_c
);

  always_comb begin
    o_onehot_c = '0;
    if (i_en) begin
      o_onehot_c[i_idx] = 1'b1;
    end
  end

endmodule : dec_4to16

// File: rtl/demux_1to16.sv
// Registered 1-to-16 demultiplexer: steers in to y[sel], all other lines 0.
module demux_1to16
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] y
);

  onehot_t w_y_next;
  onehot_t r_y;

  dec_4to16 u_dec (
    .i_idx      (sel_t'(sel)),
    .i_en       (in),
    .o_onehot_c (w_y_next)
  );

  // Output register, cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y <= '0;
    end else begin
      r_y <= w_y_next;
    end
  end

  assign y = r_y;

endmodule : demux_1to16

// File: tb/tb_demux_1to16.sv
// Self-checking bench for demux_1to16 against a behavioural reference model.
module tb_demux_1to16;

  logic        clk;
  logic        rst;
  logic        d_in;
  logic [3:0]  sel;
  logic [15:0] y;

  int checks;
  int failures;

  demux_1to16 dut (
    .clk (clk),
    .rst (rst),
    .in  (d_in),
    .sel (sel),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: y(t+1) = rst ? 0 : (in ? 1<<sel : 0)
  function automatic logic [15:0] model_y(input logic r, input logic d, input logic [3:0] s);
    int unsigned v;
    v = 0;
    if (!r && d) v = 32'd1 << s;
    return 16'(v);
  endfunction

  // Apply one cycle of inputs, then sample y just after the rising edge.
  task automatic cycle(input logic r, input logic d, input logic [3:0] s,
                       output logic [15:0] obs);
    rst  = r;
    d_in = d;
    sel  = s;
    @(posedge clk);
    #1;
    obs = y;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 4'd5, obs);
      checks++;
      if (obs !== 16'h0000) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h exp=%h", i, obs, 16'h0000);
      end
    end
    cycle(1'b0, 1'b1, 4'd5, obs);
    checks++;
    if (obs !== 16'h0020) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", obs, 16'h0020);
    end
  endtask

  task automatic test_sweep_one();
    logic [15:0] obs;
    logic [15:0] exp;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b1, 4'(k), obs);
      exp = 16'(32'd1 << k);
      checks++;
      if (obs !== exp || $countones(obs) != 1) begin
        failures++;
        $display("FAIL sweep_one sel=%0d got=%h exp=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_sweep_zero();
    logic [15:0] obs;
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 1'b0, 4'(k), obs);
      checks++;
      if (obs !== 16'h0000) begin
        failures++;
        $display("FAIL sweep_zero sel=%0d got=%h exp=%h", k, obs, 16'h0000);
      end
    end
  endtask

  task automatic test_toggle();
    logic [15:0] obs;
    logic        d_seq [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0]  s_seq [3] = '{4'd3, 4'd3, 4'd12};
    logic [15:0] e_seq [3] = '{16'h0008, 16'h0000, 16'h1000};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, d_seq[i], s_seq[i], obs);
      checks++;
      if (obs !== e_seq[i]) begin
        failures++;
        $display("FAIL toggle[%0d] got=%h exp=%h", i, obs, e_seq[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] obs;
    cycle(1'b0, 1'b1, 4'd15, obs);
    checks++;
    if (obs !== 16'h8000) begin
      failures++;
      $display("FAIL mid_reset_pre got=%h exp=%h", obs, 16'h8000);
    end
    cycle(1'b1, 1'b1, 4'd15, obs);
    checks++;
    if (obs !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset_clear got=%h exp=%h", obs, 16'h0000);
    end
    cycle(1'b0, 1'b1, 4'd15, obs);
    checks++;
    if (obs !== 16'h8000) begin
      failures++;
      $display("FAIL mid_reset_post got=%h exp=%h", obs, 16'h8000);
    end
  endtask

  task automatic test_random();
    logic [15:0] obs;
    logic [15:0] exp;
    logic        r;
    logic        d;
    logic [3:0]  s;
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 15) == 0);
      d = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      exp = model_y(r, d, s);
      cycle(r, d, s, obs);
      checks++;
      if (obs !== exp || $countones(obs) > 1) begin
        failures++;
        $display("FAIL random[%0d] rst=%0b in=%0b sel=%0d got=%h exp=%h",
                 i, r, d, s, obs, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    d_in     = 1'b0;
    sel      = 4'd0;
    test_reset();
    test_sweep_one();
    test_sweep_zero();
    test_toggle();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_demux_1to16

// File: doc/demux_1to16.md
Name: demux_1to16

Overview:
- Registered 1-to-16 demultiplexer.
- A 1-bit data input is steered to one of 16 output lines chosen by a 4-bit select; every other output is driven 0.
- Sits in the datapath wherever a single serial or status bit must be fanned out to one of 16 destinations.
- Outputs are registered on one clock with a synchronous active-high reset.

Parameters:
- N_OUT, 16, number of output lines; must equal 2**SEL_W.
- SEL_W, 4, select width in bits.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  reset, synchronous, active-high.
- in  input  1  data bit to route.
- sel  input  4  index (0..15) of the output receiving in.
- y  output  16  registered outputs; y[k] carries in when sel==k, else 0.

Behaviour:
- Combinational next-state:
  - y_next[k] = in when sel == k, else 0, for k = 0..15.
  - Equivalently, y_next = in ? (16'b1 << sel) : 16'h0000.
- Registration:
  - On each rising clk edge with rst==0, y <= y_next.
  - Latency is exactly 1 cycle from in/sel to y.
- Reset:
  - On a rising clk edge with rst==1, y <= 16'h0000, regardless of in and sel.
  - rst asserted mid-stream clears y on that edge.
  - The first edge after rst deasserts loads y_next normally.
- One-hot invariant: y has at most one bit set at any time (popcount(y) <= 1).
- in==0: y becomes 16'h0000 on the next edge for every sel value.
- Select boundaries:
  - sel==0 drives y[0].
  - sel==15 drives y[15], the MSB.
  - There is no out-of-range case.
- sel and in may change every cycle; no handshake, no hold requirement beyond standard setup/hold.
- X on sel or in is not masked; y is undefined until a valid value is registered.
- No internal state other than the 16 output flops.

Decomposition:
- Shared package demux_pkg:
  - localparams N_OUT=16 and SEL_W=4.
  - typedef sel_t (logic [SEL_W-1:0]).
  - typedef onehot_t (logic [N_OUT-1:0]).
- One natural sub-module: dec_4to16.
  - Purely combinational binary-to-one-hot decoder.
  - Inputs: sel_t idx and 1-bit en (tied to in).
  - Output: onehot_t.
- The top-level demux_1to16 instantiates dec_4to16 and holds the 16-bit output register with synchronous reset.

Test Plan:
- Reset: in=1, sel=5, rst=1 for 2 cycles -> y==16'h0000 after each edge; release rst -> next edge y==16'h0020.
- Sweep with in=1: sel=0..15, one value per cycle -> y one cycle later equals 1<<sel (16'h0001, 16'h0002, …, 16'h8000); popcount(y)==1 every cycle.
- Sweep with in=0: sel=0..15 -> y==16'h0000 on every edge.
- Per-cycle toggling: in alternates 1,0,1 with sel=3,3,12 -> y sequence 16'h0008, 16'h0000, 16'h1000, each with 1-cycle latency.
- Mid-run reset: in=1, sel=15 streaming, assert rst for one cycle -> y==16'h0000 on that edge; next edge y==16'h8000.
- Random: 1000 cycles of random in/sel with sporadic rst -> y matches the reference model y(t+1) = rst ? 0 : (in ? 1<<sel : 0); popcount(y) <= 1 at all times.
